rx_datapath: RTL
================

RX_DATAPATH -- requirements
Module: rx_datapath

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 5208: clocks per bit; legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, sent LSB first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port rx_s, output, 1 bit: synchronized rx, fed to the RX control FSM rx input.
REQ-007 SHALL have port start, input, 1 bit: from the FSM; high while the start bit is being centred.
REQ-008 SHALL have port doit, input, 1 bit: from the FSM; high while a frame is in progress.
REQ-009 SHALL have port btu, output, 1 bit: bit-time-up, a single-cycle combinational pulse.
REQ-010 SHALL have port done, output, 1 bit: all post-start bits have been sampled.
REQ-011 SHALL have port data, output, DATA_BITS wide: last received byte.
REQ-012 SHALL have port rdy, output, 1 bit: data is valid and unread.
REQ-013 SHALL have port rd, input, 1 bit: consumer acknowledge; clears rdy.
REQ-014 SHALL have ports ferr and oerr, output, 1 bit each: framing error and overrun error.

Function
REQ-015 rx_s SHALL be rx passed through two flops; rx-to-rx_s latency is 2 cycles.
REQ-016 Bit-time target SHALL be BAUD_DIV/2 (integer division) when start=1, and BAUD_DIV otherwise.
REQ-017 Bit-time counter SHALL clear to 0 when doit=0 or btu=1; otherwise it SHALL increment.
REQ-018 btu SHALL be 1 exactly when doit=1 and count == target-1.
REQ-019 Bit counter SHALL clear when doit=0 and SHALL increment on btu while start=0.
REQ-020 Shift register SHALL shift right on btu while start=0, loading rx_s into its MSB.
REQ-021 Shift register width SHALL be FRAME_BITS: DATA_BITS+1, plus 1 when parity is enabled.
REQ-022 done SHALL be 1 exactly when doit=1 and bit counter == FRAME_BITS; it SHALL hold until doit falls.
REQ-023 On the first cycle done is high (rising edge), data, rdy and the error flags SHALL load from the shift register.
REQ-024 On that load, ferr SHALL equal the inverse of the sampled stop bit (shift-register MSB).
REQ-025 On that load, oerr SHALL be set if rdy is already 1 and rd=0.
REQ-026 On that load, data SHALL be overwritten with the new byte even when oerr is set.
REQ-027 rd=1 with no load SHALL clear rdy and oerr; ferr SHALL hold until the next load.
REQ-028 rd=1 coincident with a load: the load SHALL win, rdy stays 1 and oerr stays 0.
REQ-029 If the FSM aborts (doit falls mid-frame), both counters SHALL clear, and data, rdy and flags SHALL be unchanged.

Reset
REQ-030 With rst=0 at a clock edge: rx_s sync flops SHALL be 1; counters, shift register and data SHALL be 0.
REQ-031 With rst=0 at a clock edge: rdy, ferr, oerr, perr and the done edge-detect flop SHALL be 0.
REQ-032 btu and done SHALL read 0 while in reset.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame, with no load.

Configuration
REQ-034 With macro RX_PARITY_EN defined, one even-parity bit SHALL follow the data bits, and FRAME_BITS = DATA_BITS+2.
REQ-035 With RX_PARITY_EN defined, output perr SHALL load on the load cycle as the XOR of the data and parity bits; its reset value is 0.
REQ-036 With RX_PARITY_EN defined, rd SHALL NOT clear perr; perr holds until the next load.
REQ-037 Without RX_PARITY_EN, the perr port and parity logic SHALL be absent, and FRAME_BITS = DATA_BITS+1.

Structure
REQ-038 Shared package rx_pkg SHALL hold the default BAUD_DIV and DATA_BITS, the FRAME_BITS derivation, and the counter-width function (clog2 of BAUD_DIV).
REQ-039 The two-flop synchronizer SHALL be sub-module rx_sync; all remaining logic SHALL be flat in rx_datapath.

Verification (BAUD_DIV=16, paired with the RX FSM)
REQ-040 Frame 0xA5 with stop bit 1 -> btu 8 cycles after the start-bit edge reaches rx_s, then every 16 cycles; data=0xA5, rdy=1, ferr=0.
REQ-041 Frame 0x3C with stop bit 0 -> data=0x3C, ferr=1, rdy=1.
REQ-042 Frames 0x11 then 0x22 with no rd -> data=0x22, oerr=1; a following rd pulse clears rdy and oerr.
REQ-043 A 4-cycle low glitch on rx -> no btu, rdy stays 0, and both counters return to 0.
REQ-044 rst=0 at data bit 4 of a frame -> all outputs at reset values and no rdy; the next frame 0x5A is received correctly.
REQ-045 With RX_PARITY_EN, frame 0x07 with parity 0 -> perr=1; with parity 1 -> perr=0.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared defaults and frame geometry for the UART receive datapath.
// RX_PARITY_EN adds one even-parity bit to every frame.
package rx_pkg;

  localparam int DEF_BAUD_DIV  = 5208;
  localparam int DEF_DATA_BITS = 8;

`ifdef RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Bits captured after the start bit: data, optional parity, stop.
  function automatic int frame_bits(input int data_bits);
    return data_bits + PARITY_BITS + 1;
  endfunction

  function automatic int cnt_width(input int baud_div);
    return $clog2(baud_div);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = rx;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q;

endmodule

// File: rtl/rx_datapath.sv
// UART receive datapath driven by the RX control FSM (start/doit): bit timing, frame
// capture and the data/rdy/error holding registers. Define RX_PARITY_EN for parity and perr.
module rx_datapath
  import rx_pkg::*;
#(
  parameter int BAUD_DIV  = DEF_BAUD_DIV,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 rx_s,
  input  logic                 start,
  input  logic                 doit,
  output logic                 btu,
  output logic                 done,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  input  logic                 rd,
  output logic                 ferr,
`ifdef RX_PARITY_EN
  output logic                 perr,
`endif
  output logic                 oerr
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS);
  localparam int CW         = cnt_width(BAUD_DIV);
  localparam int BW         = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] TGT_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] TGT_HALF = CW'(BAUD_DIV / 2 - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  rdy_q, rdy_d;
  logic                  ferr_q, ferr_d;
  logic                  oerr_q, oerr_d;
  logic                  done_q, done_d;
  logic                  load;

  rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  // Half a bit time while centring on the start bit, a full bit time afterwards.
  assign btu  = rst && doit && (cnt_q == (start ? TGT_HALF : TGT_FULL));
  assign done = rst && doit && (bit_cnt_q == BW'(FRAME_BITS));
  assign load = done && !done_q;

  always_comb begin
    cnt_d     = (!doit || btu) ? '0 : cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    if (!doit) begin
      bit_cnt_d = '0;
    end else if (btu && !start) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      shreg_d   = {rx_s, shreg_q[FRAME_BITS-1:1]};
    end

    done_d = done;
    data_d = data_q;
    rdy_d  = rdy_q;
    ferr_d = ferr_q;
    oerr_d = oerr_q;
    // A load overrides a coincident rd so a fresh byte is never lost.
    if (load) begin
      data_d = shreg_q[DATA_BITS-1:0];
      rdy_d  = 1'b1;
      ferr_d = !shreg_q[FRAME_BITS-1];
      oerr_d = rdy_q && !rd;
    end else if (rd) begin
      rdy_d  = 1'b0;
      oerr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
      done_q    <= done_d;
    end
  end

`ifdef RX_PARITY_EN
  logic perr_q, perr_d;

  // Even parity: data plus parity bit XOR to zero on a clean frame.
  always_comb begin
    perr_d = perr_q;
    if (load) begin
      perr_d = ^shreg_q[DATA_BITS:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign perr = perr_q;
`endif

  assign data = data_q;
  assign rdy  = rdy_q;
  assign ferr = ferr_q;
  assign oerr = oerr_q;

endmodule
